// File: rtl/event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : event_encoder
// Description : Sequential 4-to-2 encoder. Captures request pulses on d0..d3
//               and holds them as pending events. Pending events are emitted
//               one at a time as a 2-bit code {a,b} under a valid/ready
//               handshake. ovf pulses when an event merges into a request
//               that is already pending.
//               Build option EVENT_ENCODER_RR_EN selects round-robin
//               arbitration. Without it, the highest pending index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module event_encoder (
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic ready,
    output logic a,
    output logic b,
    output logic valid,
    output logic ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_pending;
    logic       r_a;
    logic       r_b;
    logic       r_valid;
    logic       r_ovf;

    logic [3:0] w_req;
    logic [3:0] w_clr;
    logic [3:0] w_merge;
    logic       w_accept;
    logic [1:0] w_grant;

`ifdef EVENT_ENCODER_RR_EN
    // Index of the most recent grant. Reset to 3 so that the first search
    // order is 0, 1, 2, 3.
    logic [1:0] r_ptr;
    logic [1:0] w_cand;
`endif

    assign w_req    = {d3, d2, d1, d0};
    // valid is only ever high in HOLD, so this is the handshake completion.
    assign w_accept = r_valid & ready;
    // Events landing on a bit that is pending and not being retired this edge.
    assign w_merge  = w_req & r_pending & ~w_clr;

    // One-hot clear mask for the code being accepted this edge
    always_comb begin
        w_clr = 4'b0000;
        if (w_accept) begin
            w_clr[{r_a, r_b}] = 1'b1;
        end
    end

`ifdef EVENT_ENCODER_RR_EN
    // Round-robin pick: the search starts at r_ptr+1 and wraps. The loop walks
    // from the farthest candidate to the nearest, so the nearest pending
    // candidate is the one that remains.
    always_comb begin
        w_grant = 2'd0;
        w_cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (r_pending[w_cand]) begin
                w_grant = w_cand;
            end
        end
    end
`else
    // Fixed priority pick: later (higher) indices overwrite, so d3 wins
    always_comb begin
        w_grant = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i]) begin
                w_grant = 2'(i);
            end
        end
    end
`endif

    // Pending events: set beats the clear caused by acceptance. Merges give
    // one ovf pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 4'b0000;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_req;
            r_ovf     <= |w_merge;
        end
    end

    // Handshake state machine with registered code and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_valid <= 1'b0;
`ifdef EVENT_ENCODER_RR_EN
            r_ptr   <= 2'd3;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Only registered pending is considered. Same-edge
                    // requests wait one more cycle.
                    if (r_pending != 4'b0000) begin
                        r_a     <= w_grant[1];
                        r_b     <= w_grant[0];
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
`ifdef EVENT_ENCODER_RR_EN
                        r_ptr   <= w_grant;
`endif
                    end
                end
                ST_HOLD: begin
                    // Code stays put until the consumer takes it
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign valid = r_valid;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_encoder
// Description : Scoreboard bench for event_encoder. Stimulus pushes expected
//               codes. A negedge monitor pops and compares on each handshake.
//               Expectations follow EVENT_ENCODER_RR_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ready;
    logic [3:0] d;
    logic       a;
    logic       b;
    logic       valid;
    logic       ovf;

    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    int         checks    = 0;
    int         errors    = 0;
    int         ovf_count = 0;
    int         base;
    int         vcount;
    logic [6:0] pat;

    always #5 clk = ~clk;

    event_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d[0]),
        .d1    (d[1]),
        .d2    (d[2]),
        .d3    (d[3]),
        .ready (ready),
        .a     (a),
        .b     (b),
        .valid (valid),
        .ovf   (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a one-cycle request mask. On return, the capture edge has passed.
    task automatic pulse(input logic [3:0] m);
        @(posedge clk);
        #1 d = m;
        @(posedge clk);
        #1 d = 4'b0000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: count ovf pulses. On each handshake, compare the code with
    // the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ovf === 1'b1) ovf_count++;
                if (valid === 1'b1 && ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_code: got %0d expected none", {a, b});
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("code", {30'd0, a, b}, {30'd0, mon_exp});
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        d     = 4'b0000;
        ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("rst_state", {a, b, valid, ovf}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", {a, b, valid, ovf}, 4'b0000);

        // Single d2 pulse, ready high: valid is high for exactly one cycle
        ready = 1'b1;
        exp_q.push_back(2'b10);
        pulse(4'b0100);
        @(negedge clk);
        check("t1_valid_edgeN", valid, 0);
        @(negedge clk);
        check("t1_valid_edgeN1", valid, 1);
        check("t1_code", {a, b}, 2'b10);
        @(negedge clk);
        check("t1_valid_edgeN2", valid, 0);
        drain();
        check("t1_ovf", ovf_count, 0);

        // Burst d0, d1, d3 on the same edge, arbitration order
        do_reset();
        ready = 1'b1;
        base  = ovf_count;
`ifdef EVENT_ENCODER_RR_EN
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
`endif
        pulse(4'b1011);
        pat = 7'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pat = {pat[5:0], valid};
        end
        check("t2_valid_pattern", pat, 7'b0101010);
        drain();
`ifdef EVENT_ENCODER_RR_EN
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
`endif
        pulse(4'b1001);
        drain();
        check("t2_ovf", ovf_count - base, 0);

        // Hold with ready low, merge a second d1 event during the hold
        ready = 1'b0;
        base  = ovf_count;
        exp_q.push_back(2'b01);
        pulse(4'b0010);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 d = (i == 1) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            check("t3_hold_stable", {valid, a, b}, 3'b101);
        end
        @(posedge clk);
        #1 d = 4'b0000;
        ready = 1'b1;
        drain();
        check("t3_ovf", ovf_count - base, 1);

        // Re-request on the acceptance edge: set wins, no ovf
        ready = 1'b0;
        base  = ovf_count;
        exp_q.push_back(2'b10);
        pulse(4'b0100);
        @(negedge clk);
        @(negedge clk);
        check("t4_hold", {valid, a, b}, 3'b110);
        @(posedge clk);
        #1 ready = 1'b1;
        d = 4'b0100;
        exp_q.push_back(2'b10);
        @(posedge clk);
        #1 d = 4'b0000;
        drain();
        check("t4_ovf", ovf_count - base, 0);

        // Asynchronous reset in the middle of a HOLD
        ready = 1'b0;
        pulse(4'b1001);
        @(negedge clk);
        @(negedge clk);
        check("t5_hold", {valid, a, b}, 3'b111);
        #2 rst_n = 1'b0;
        #1 check("t5_async_rst", {a, b, valid, ovf}, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        check("t5_no_code_after_rst", vcount, 0);
`ifdef EVENT_ENCODER_RR_EN
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b00);
`endif
        pulse(4'b1001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_encoder.md
# event_encoder

Sequential 4-to-2 encoder: the sending-side counterpart of the team's 2:4 decoder. It captures request pulses on four one-hot-style lines, holds them pending, and emits them one at a time as a 2-bit code (a = MSB, b = LSB) under a valid/ready handshake. The code can drive a decoder downstream directly. It sits between asynchronous-ish event sources (already synchronised to clk) and a single shared consumer.

## Interface
Parameters:
- none; width fixed at 4 request lines / 2-bit code.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- d0, d1, d2, d3  input  1 each  request lines; sampled high on a rising edge = one event on that line
- a  output  1  code MSB (registered)
- b  output  1  code LSB (registered)
- valid  output  1  {a,b} holds a code (registered)
- ready  input  1  consumer accepts the code on an edge where valid && ready
- ovf  output  1  one-cycle pulse: an event merged into an already-pending request

## Operation
- pending[3:0] register; bit i set on any edge where di = 1.
- Bit i clears on the edge where the code i is accepted (valid && ready), unless di = 1 on that same edge. In that case set wins and the bit stays pending as a new event.
- State machine, two states:
  - IDLE: valid = 0. If pending != 0, select an index per the arbitration rule, load {a,b} = index, set valid, go to HOLD. Selection uses the registered pending only; same-edge inputs are not visible.
  - HOLD: valid = 1 and {a,b} stable. On valid && ready: clear that pending bit, valid = 0, go to IDLE. Otherwise stay, with {a,b} and valid unchanged.
- Code mapping is the inverse of the decoder: d0 -> 00, d1 -> 01, d2 -> 10, d3 -> 11.
- ovf: registered pulse the edge after any di = 1 while pending[i] was already 1 and not being cleared that edge. Multiple merges in one cycle still give a single pulse.
- Reset (rst_n = 0 at any time, including in HOLD): pending = 0, a = 0, b = 0, valid = 0, ovf = 0, state = IDLE, rr pointer = 3. In-flight and pending events are discarded.

## Timing
- Input latency: di high at edge N sets pending at N; valid = 1 after edge N+1 (valid visible in cycle N+1 to N+2). Minimum latency is 1 cycle after capture.
- Throughput: at most one code per 2 cycles (HOLD -> IDLE -> HOLD).
- With ready held high, valid is high for exactly one cycle per code.
- {a,b} change only on the IDLE -> HOLD edge. After acceptance they keep their last value, which is don't-care while valid = 0.
- ready while valid = 0 is ignored.
- No combinational path from any input to any output.

## Configuration
- Macro: EVENT_ENCODER_RR_EN.
- Defined: round-robin arbitration. A 2-bit pointer holds the last granted index. The search starts at pointer+1 and wraps 3 -> 0. The pointer updates on the IDLE -> HOLD load. After reset (pointer = 3) the search order is 0, 1, 2, 3.
- Undefined: fixed priority, highest index wins (d3 > d2 > d1 > d0). No pointer register.

## Test plan
- Reset, then single pulse on d2 with ready = 1 → valid high for exactly one cycle 2 edges after the pulse, {a,b} = 10, ovf never asserted.
- Pulses on d0, d1 and d3 on the same edge, ready = 1, fixed priority → codes 11, 01, 00, with valid high one cycle in every two.
- Same stimulus as the previous test with EVENT_ENCODER_RR_EN defined → codes 00, 01, 11. Then a second burst on d0 and d3 → 00, 11.
- d1 pulse, ready = 0 for 5 cycles, second d1 pulse during the hold → valid and {a,b} = 01 stable throughout, ovf = 1 for one cycle. After ready = 1, exactly one code 01 is delivered.
- d2 high on the same edge that code 10 is accepted → code 10 is delivered again on the next grant, with no ovf.
- rst_n pulled low mid-HOLD with code 11 pending and d0 pending → all outputs 0 immediately (asynchronously). After release, no code is emitted until a new pulse.
